// File: rtl/lcg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcg_pkg
// Description : Shared LCG constants and checker state encoding. The stream
//               generator and lcg_checker both use these defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package lcg_pkg;

  // Default recurrence x' = LCG_A * x + LCG_C (mod 2^N)
  localparam int unsigned LCG_A = 32'd1103515245;
  localparam int unsigned LCG_C = 32'd12345;

  // Checker sequencing states
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage : lcg_pkg
`default_nettype wire

// File: rtl/lcg_step.sv
`default_nettype none
// ============================================================================
// Module      : lcg_step
// Description : Combinational single LCG step, next = A * x + C (mod 2^N).
//               A and C are truncated to N bits. The product keeps only its
//               low N bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lcg_step
  import lcg_pkg::*;
#(
  parameter int          N = 32,
  parameter int unsigned A = LCG_A,
  parameter int unsigned C = LCG_C
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] next
);

  localparam logic [N-1:0] A_N = N'(A);
  localparam logic [N-1:0] C_N = N'(C);

  // All operands are N bits wide, so the result wraps modulo 2^N
  assign next = A_N * x + C_N;

endmodule : lcg_step
`default_nettype wire

// File: rtl/lcg_checker.sv
`default_nettype none
// ============================================================================
// Module      : lcg_checker
// Description : Receive-side checker for an LCG pseudo-random stream. It seeds
//               from the first sample, locks after LOCK_CNT consecutive
//               correct predictions, then flywheels its own prediction to
//               count mismatches and to detect loss of sequence.
//               Optional statistics counters: define LCG_CHECKER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lcg_checker
  import lcg_pkg::*;
#(
  parameter int          N           = 32,
  parameter int unsigned A           = LCG_A,
  parameter int unsigned C           = LCG_C,
  parameter int          LOCK_CNT    = 4,
  parameter int          LOSS_THRESH = 8
) (
  input  logic         clk50M,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  input  logic         clr,
  output logic         locked,
  output logic         mismatch,
  output logic         lost,
  output logic [15:0]  err_count,
  output logic [31:0]  sample_count
);

  localparam int GW = (LOCK_CNT    > 1) ? $clog2(LOCK_CNT + 1)    : 1;
  localparam int BW = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;

  state_t        state;
  logic [N-1:0]  expected;
  logic [GW-1:0] good_cnt;
  logic [BW-1:0] bad_run;

  logic [N-1:0]  next_from_x;
  logic [N-1:0]  next_from_exp;
  logic          sample_ok;
  logic          locked_miss;

  // Seed/track path: successor of the received sample
  lcg_step #(.N(N), .A(A), .C(C)) u_step_x (
    .x    (in_data),
    .next (next_from_x)
  );

  // Flywheel path: successor of the current prediction
  lcg_step #(.N(N), .A(A), .C(C)) u_step_fly (
    .x    (expected),
    .next (next_from_exp)
  );

  assign sample_ok   = (in_data == expected);
  assign locked_miss = in_valid && (state == LOCKED) && !sample_ok;

  // Sequencing FSM with registered locked/mismatch/lost outputs
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      expected <= '0;
      good_cnt <= '0;
      bad_run  <= '0;
      locked   <= 1'b0;
      mismatch <= 1'b0;
      lost     <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      lost     <= 1'b0;
      if (in_valid) begin
        case (state)
          SEARCH: begin
            expected <= next_from_x;
            good_cnt <= '0;
            state    <= TRACK;
          end
          TRACK: begin
            expected <= next_from_x;
            if (sample_ok) begin
              good_cnt <= good_cnt + 1'b1;
              if (good_cnt == GW'(LOCK_CNT - 1)) begin
                state   <= LOCKED;
                locked  <= 1'b1;
                bad_run <= '0;
              end
            end else begin
              // Wrong guess while acquiring: restart from this sample
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (sample_ok) begin
              bad_run  <= '0;
              expected <= next_from_x;
            end else begin
              // Do not trust a corrupted sample; advance our own prediction
              mismatch <= 1'b1;
              expected <= next_from_exp;
              if (bad_run == BW'(LOSS_THRESH - 1)) begin
                bad_run <= '0;
                lost    <= 1'b1;
                locked  <= 1'b0;
                state   <= SEARCH;
              end else begin
                bad_run <= bad_run + 1'b1;
              end
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LCG_CHECKER_STATS_EN
  // Statistics: saturating mismatch count and wrapping sample count; clr wins
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      err_count    <= '0;
      sample_count <= '0;
    end else if (clr) begin
      err_count    <= '0;
      sample_count <= '0;
    end else begin
      if (in_valid) begin
        sample_count <= sample_count + 32'd1;
      end
      if (locked_miss && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`else
  logic unused_stats;

  assign err_count    = '0;
  assign sample_count = '0;
  assign unused_stats = clr ^ locked_miss;
`endif

endmodule : lcg_checker
`default_nettype wire
